// File: rtl/ecc_pkg.sv
// Shared constants for the ECC datapath: default operand width and the P-256 prime.
package ecc_pkg;

    localparam int ECC_WIDTH = 256;

    // NIST P-256 field prime
    localparam logic [ECC_WIDTH-1:0] P256 =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

endpackage

// File: rtl/add_sub_w.sv
// WIDTH-bit adder/subtractor with carry (add) or borrow (sub) out.
// Shared by the modular subtractor and the modular adder.
module add_sub_w #(
    parameter int WIDTH = 256
) (
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carryOut
);

    logic [WIDTH:0] ext;

    // One extra bit holds the carry on add, or the borrow on subtract
    always_comb begin
        ext = '0;
        if (sub)
            ext = {1'b0, a} - {1'b0, b};
        else
            ext = {1'b0, a} + {1'b0, b};
    end

    assign result   = ext[WIDTH-1:0];
    assign carryOut = ext[WIDTH];

endmodule

// File: rtl/sub_mod.sv
// Two-stage pipelined modular subtractor: out_data = (opA - opB) mod opM.
// Stage 1 subtracts and records the borrow; stage 2 adds the modulus back
// once if the subtraction borrowed. Fixed 2-cycle latency, no stalls.
module sub_mod
    import ecc_pkg::*;
#(
    parameter int WIDTH = ECC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] opM,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int STAGES = 2;

    logic [STAGES:1]  vldPipe;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] dReg;
    logic             borrowReg;
    logic [WIDTH-1:0] mReg;
    logic [WIDTH-1:0] wrapSum;
    logic             unusedCarry;   // wrap-around on d + M is intended

    add_sub_w #(.WIDTH(WIDTH)) uSub (
        .sub      (1'b1),
        .a        (opA),
        .b        (opB),
        .result   (diff),
        .carryOut (borrow)
    );

    add_sub_w #(.WIDTH(WIDTH)) uAdd (
        .sub      (1'b0),
        .a        (dReg),
        .b        (mReg),
        .result   (wrapSum),
        .carryOut (unusedCarry)
    );

    // Valid shift register; a reset drops everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vldPipe <= '0;
        else
            vldPipe <= {vldPipe[STAGES-1:1], in_valid};
    end

    // Stage 1: capture difference, borrow and modulus for accepted operations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dReg      <= '0;
            borrowReg <= 1'b0;
            mReg      <= '0;
        end else if (in_valid) begin
            dReg      <= diff;
            borrowReg <= borrow;
            mReg      <= opM;
        end
    end

    // Stage 2: single conditional add-back; holds its value across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_data <= '0;
        else if (vldPipe[1])
            out_data <= borrowReg ? wrapSum : dReg;
    end

    assign out_valid = vldPipe[STAGES];

endmodule

// File: tb/tb_sub_mod.sv
// Scoreboard bench for sub_mod: driver pushes expected results, negedge monitor pops and compares.
module tb_sub_mod;
    import ecc_pkg::*;

    localparam int W = ECC_WIDTH;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    logic [W-1:0] opM = '0;
    logic         out_valid;
    logic [W-1:0] out_data;

    typedef struct {
        logic [W-1:0] val;
        int           cyc;
    } exp_t;

    exp_t         expQ[$];
    exp_t         monE;
    int           cyc = 0;
    int           nChecks = 0;
    int           nFails = 0;
    logic [W-1:0] lastExp = '0;

    sub_mod #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .opA       (opA),
        .opB       (opB),
        .opM       (opM),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: mathematical (a - b) mod m for a, b < m
    function automatic logic [W-1:0] modSub(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
        logic [W:0] t;
        if (a >= b) t = {1'b0, a} - {1'b0, b};
        else        t = {1'b0, a} + {1'b0, m} - {1'b0, b};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] randW();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [W-1:0] randBelow(input logic [W-1:0] m);
        logic [W-1:0] r;
        r = randW();
        while (r >= m) r = randW();
        return r;
    endfunction

    task automatic issueExp(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] m, input logic [W-1:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        opA = a;
        opB = b;
        opM = m;
        x.val = e;
        x.cyc = cyc + 2;
        expQ.push_back(x);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
        issueExp(a, b, m, modSub(a, b, m));
    endtask

    // Bubble with garbage operands: nothing may load
    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opA = randW();
        opB = randW();
        opM = randW();
    endtask

    // Monitor: compare every presented result in order with its expected cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkInt("unexpected_out_valid", 1, 0);
                end else begin
                    monE = expQ.pop_front();
                    check("out_data", out_data, monE.val);
                    checkInt("latency_cycle", cyc, monE.cyc);
                    lastExp = monE.val;
                end
            end else begin
                check("hold_out_data", out_data, lastExp);
                if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                    checkInt("missing_out_valid", 0, 1);
                    void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000ns");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] p1;
        p1 = P256 - 1;

        // Reset state
        #2;
        checkInt("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", out_data, '0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Small-modulus directed cases
        issue(5, 7, 23);
        idle(); idle(); idle();
        issue(20, 3, 23);
        issue(11, 11, 23);
        issue(0, 22, 23);
        issue(0, 1, 23);
        issue(9, 0, 23);
        issueExp(30, 2, 23, 28);          // out of contract: no borrow, no reduction
        issueExp(1, 30, 23, W'(1 - 30 + 23)); // out of contract: single add-back, wraps
        idle(); idle();

        // P-256 edges
        issue(0, 1, P256);
        issue(0, p1, P256);
        issue(p1, 0, P256);
        issue(p1, p1, P256);
        idle(); idle();

        // Continuous streaming
        for (int i = 0; i < 1000; i++) issue(randBelow(P256), randBelow(P256), P256);
        idle(); idle(); idle();

        // Streaming with random bubbles
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) idle();
            else issue(randBelow(P256), randBelow(P256), P256);
        end
        idle(); idle(); idle();

        // Reset mid-stream with two operations in flight
        issue(5, 7, 23);
        issue(3, 9, 23);
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkInt("midreset_out_valid", int'(out_valid), 0);
        check("midreset_out_data", out_data, '0);
        expQ.delete();
        lastExp = '0;
        @(posedge clk);
        #4 rst = 1'b0;
        repeat (4) idle();
        issue(2, 15, 23);
        repeat (4) idle();

        checkInt("queue_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
